// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, sizing and the vector
// table layout in data memory.
package irq_pkg;

  localparam int unsigned NUM_IRQ       = 8;
  localparam int unsigned ID_W          = $clog2(NUM_IRQ);
  localparam logic [9:0]  VECTOR_BASE   = 10'd960;
  localparam int unsigned VECTOR_STRIDE = 3;
  localparam logic [9:0]  MASK_ADDR     = 10'd985;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StActive = 2'd2
  } irqState_e;

  // Wraps modulo 1024 like the 10-bit data memory address it feeds.
  function automatic logic [9:0] vectorOf(input logic [ID_W-1:0] id);
    return VECTOR_BASE + 10'(id) * 10'(VECTOR_STRIDE);
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt line: 2-flop synchroniser followed by a rising-edge detector.
module irq_edge_sync (
  input  logic clk,
  input  logic rstN,
  input  logic irqRaw,
  output logic irqEdge
);

  logic metaQ, syncQ, prevQ;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      metaQ <= 1'b0;
      syncQ <= 1'b0;
      prevQ <= 1'b0;
    end else begin
      metaQ <= irqRaw;
      syncQ <= metaQ;
      prevQ <= syncQ;
    end
  end

  assign irqEdge = syncQ & ~prevQ;

endmodule

// File: rtl/interrupt_controller.sv
// Latches interrupt edges, masks them and presents a single fixed-priority request
// with its ISR vector; one interrupt in service at a time.
module interrupt_controller
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rstN,
  input  logic [NUM_IRQ-1:0] irqIn,
  input  logic [NUM_IRQ-1:0] interruptMask,
  input  logic               globalEnable,
  input  logic               irqAck,
  input  logic               irqDone,
  output logic               irqReq,
  output logic [ID_W-1:0]    irqId,
  output logic [9:0]         irqVector,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] candidates;
  logic [NUM_IRQ-1:0] clearMask;
  logic [NUM_IRQ-1:0] pendingD;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    irqIdD;
  logic [9:0]         irqVectorD;
  logic               irqReqD;
  irqState_e          stateQ, stateD;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : gLine
    irq_edge_sync uSync (
      .clk     (clk),
      .rstN    (rstN),
      .irqRaw  (irqIn[i]),
      .irqEdge (rise[i])
    );
  end

  assign candidates = pending & interruptMask;

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (candidates[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    stateD     = stateQ;
    irqReqD    = irqReq;
    irqIdD     = irqId;
    irqVectorD = irqVector;
    clearMask  = '0;
    case (stateQ)
      StIdle: begin
        if (globalEnable && (|candidates)) begin
          irqIdD     = winner;
          irqVectorD = vectorOf(winner);
          irqReqD    = 1'b1;
          stateD     = StReq;
        end
      end
      StReq: begin
        if (irqAck) begin
          clearMask[irqId] = 1'b1;
          irqReqD          = 1'b0;
          stateD           = StActive;
        end else if (!interruptMask[irqId] || !globalEnable) begin
          irqReqD = 1'b0;
          stateD  = StIdle;
        end
      end
      StActive: begin
        if (irqDone) stateD = StIdle;
      end
      default: begin
        irqReqD = 1'b0;
        stateD  = StIdle;
      end
    endcase
    // A fresh edge in the ack cycle beats the clear.
    pendingD = (pending & ~clearMask) | rise;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ    <= StIdle;
      irqReq    <= 1'b0;
      irqId     <= '0;
      irqVector <= '0;
      pending   <= '0;
    end else begin
      stateQ    <= stateD;
      irqReq    <= irqReqD;
      irqId     <= irqIdD;
      irqVector <= irqVectorD;
      pending   <= pendingD;
    end
  end

endmodule
